// File: rtl/deserializer_align.sv
// Receive aligner: shifts in the serial line, locks onto K28.5 comma boundaries
// and presents aligned 10-bit code groups while LOCKED.
module deserializer_align #(
  parameter int unsigned SYNC_COMMAS = 3,
  parameter int unsigned LOSS_THRESH = 4,
  parameter logic [9:0]  COMMA_N     = 10'b0011111010,
  parameter logic [9:0]  COMMA_P     = 10'b1100000101
) (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_bit_en,
  input  logic       i_ser_data,
  output logic [9:0] o_10b,
  output logic       o_valid,
  output logic       o_is_comma,
  output logic       o_aligned,
  output logic       o_align_err,
  output logic [1:0] o_state
);

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    SYNC   = 2'b01,
    LOCKED = 2'b10
  } state_t;

  localparam logic [3:0] SYNC_N = 4'(SYNC_COMMAS);
  localparam logic [3:0] LOSS_N = 4'(LOSS_THRESH);

  state_t     state_r, state_s;
  logic [9:0] sr_r, sr_s;
  logic [3:0] bit_cnt_r, bit_cnt_s;
  logic [3:0] comma_cnt_r, comma_cnt_s;
  logic [3:0] err_cnt_r, err_cnt_s;
  logic [9:0] data_r, data_s;
  logic       valid_r, valid_s;
  logic       is_comma_r, is_comma_s;
  logic       aligned_r, aligned_s;
  logic       align_err_r, align_err_s;

  logic [9:0] win_s;
  logic       is_c_s;
  logic       boundary_s;
  logic [3:0] comma_inc_s;
  logic [3:0] err_inc_s;

  assign win_s       = {i_ser_data, sr_r[9:1]};
  assign is_c_s      = (win_s == COMMA_N) || (win_s == COMMA_P);
  assign boundary_s  = (bit_cnt_r == 4'd9);
  assign comma_inc_s = comma_cnt_r + 4'd1;
  assign err_inc_s   = err_cnt_r + 4'd1;

  // Next-state and next-output computation for the alignment FSM
  always_comb begin
    state_s     = state_r;
    sr_s        = sr_r;
    bit_cnt_s   = bit_cnt_r;
    comma_cnt_s = comma_cnt_r;
    err_cnt_s   = err_cnt_r;
    data_s      = data_r;
    valid_s     = 1'b0;
    is_comma_s  = is_comma_r;
    aligned_s   = aligned_r;
    align_err_s = 1'b0;
    if (i_bit_en) begin
      sr_s      = win_s;
      bit_cnt_s = boundary_s ? 4'd0 : (bit_cnt_r + 4'd1);
      case (state_r)
        HUNT: begin
          if (is_c_s) begin
            bit_cnt_s   = 4'd0;
            comma_cnt_s = 4'd1;
            state_s     = SYNC;
          end else begin
            state_s = HUNT;
          end
        end
        SYNC: begin
          if (boundary_s && is_c_s) begin
            comma_cnt_s = comma_inc_s;
            if (comma_inc_s >= SYNC_N) begin
              state_s   = LOCKED;
              err_cnt_s = 4'd0;
              aligned_s = 1'b1;
            end else begin
              state_s = SYNC;
            end
          end else if (!boundary_s && is_c_s) begin
            // Comma on a new phase: restart the count from this comma
            bit_cnt_s   = 4'd0;
            comma_cnt_s = 4'd1;
            align_err_s = 1'b1;
          end else begin
            state_s = SYNC;
          end
        end
        LOCKED: begin
          if (boundary_s) begin
            data_s     = win_s;
            valid_s    = 1'b1;
            is_comma_s = is_c_s;
            if (is_c_s) begin
              err_cnt_s = 4'd0;
            end else begin
              err_cnt_s = err_cnt_r;
            end
          end else if (is_c_s) begin
            // Phase is kept while locked; only count the disagreement
            align_err_s = 1'b1;
            if (err_inc_s >= LOSS_N) begin
              state_s     = HUNT;
              aligned_s   = 1'b0;
              comma_cnt_s = 4'd0;
              err_cnt_s   = 4'd0;
            end else begin
              err_cnt_s = err_inc_s;
            end
          end else begin
            state_s = LOCKED;
          end
        end
        default: begin
          state_s     = HUNT;
          aligned_s   = 1'b0;
          comma_cnt_s = 4'd0;
          err_cnt_s   = 4'd0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_r     <= HUNT;
      sr_r        <= 10'd0;
      bit_cnt_r   <= 4'd0;
      comma_cnt_r <= 4'd0;
      err_cnt_r   <= 4'd0;
      data_r      <= 10'd0;
      valid_r     <= 1'b0;
      is_comma_r  <= 1'b0;
      aligned_r   <= 1'b0;
      align_err_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      sr_r        <= sr_s;
      bit_cnt_r   <= bit_cnt_s;
      comma_cnt_r <= comma_cnt_s;
      err_cnt_r   <= err_cnt_s;
      data_r      <= data_s;
      valid_r     <= valid_s;
      is_comma_r  <= is_comma_s;
      aligned_r   <= aligned_s;
      align_err_r <= align_err_s;
    end
  end

  assign o_10b       = data_r;
  assign o_valid     = valid_r;
  assign o_is_comma  = is_comma_r;
  assign o_aligned   = aligned_r;
  assign o_align_err = align_err_r;
  assign o_state     = state_r;

endmodule

// File: tb/tb_deserializer_align.sv
// Self-checking bench for deserializer_align: vector table plus scoreboard of
// expected code groups, with hand-built lock, realign, loss, gap and loopback streams.
`timescale 1ns/1ps
module tb_deserializer_align;

  localparam logic [9:0] CN = 10'b0011111010;
  localparam logic [9:0] CP = 10'b1100000101;

  logic       clk = 1'b0;
  logic       i_rst_n, i_bit_en, i_ser_data;
  logic [9:0] o_10b;
  logic       o_valid, o_is_comma, o_aligned, o_align_err;
  logic [1:0] o_state;

  always #5 clk = ~clk;

  deserializer_align dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_bit_en(i_bit_en), .i_ser_data(i_ser_data),
    .o_10b(o_10b), .o_valid(o_valid), .o_is_comma(o_is_comma),
    .o_aligned(o_aligned), .o_align_err(o_align_err), .o_state(o_state)
  );

  typedef struct packed {logic [9:0] w; logic c;} exp_t;
  exp_t       sbq[$];
  exp_t       tbl[9];
  exp_t       last_push;
  logic [9:0] pool[5];
  logic [5:0] t6[32];
  logic [3:0] t4[8];
  int         checks = 0, failures = 0, err_seen = 0;
  logic       track = 1'b0;
  logic [9:0] acc = 10'd0;
  int         nb = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // While tracking, every 10 bits on the locked phase must come back as one word
  task automatic send_bit(input logic b);
    i_ser_data = b;
    i_bit_en   = 1'b1;
    if (track) begin
      acc[nb] = b;
      nb++;
      if (nb == 10) begin
        last_push = '{w: acc, c: ((acc == CN) || (acc == CP))};
        sbq.push_back(last_push);
        nb = 0;
      end
    end
    @(posedge clk); #1;
    i_bit_en = 1'b0;
  endtask

  task automatic send_word(input logic [9:0] w);
    for (int i = 0; i < 10; i++) send_bit(w[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      i_bit_en   = 1'b0;
      i_ser_data = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  // 8b/10b encoder producing {rd_out, abcdei, fghj}; rd 0 = RD-
  function automatic logic [10:0] enc(input logic [7:0] d, input logic rd);
    logic [5:0] c6;
    logic [3:0] c4;
    logic       rd1, rd2;
    int         x, y;
    x  = int'(d[4:0]);
    y  = int'(d[7:5]);
    c6 = t6[d[4:0]];
    if (rd && (($countones(c6) != 3) || (x == 7))) c6 = ~c6;
    rd1 = ($countones(c6) == 3) ? rd : ~rd;
    c4 = t4[d[7:5]];
    if ((y == 7) && ((!rd1 && (x == 17 || x == 18 || x == 20)) ||
                     (rd1 && (x == 11 || x == 13 || x == 14)))) c4 = 4'b0111;
    if (rd1 && (($countones(c4) != 2) || (y == 3))) c4 = ~c4;
    rd2 = ($countones(c4) == 2) ? rd1 : ~rd1;
    return {rd2, c6, c4};
  endfunction

  // Scoreboard: every o_valid must match the oldest expected word
  always @(negedge clk) begin
    if (o_align_err === 1'b1) err_seen++;
    if (o_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: o_valid=1 with no word expected, o_10b=0x%0h at %0t", o_10b, $time);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_10b", 32'(o_10b), 32'(e.w));
        chk("sb_comma", 32'(o_is_comma), 32'(e.c));
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         e0;
    logic       rd;
    logic [10:0] r;
    logic [9:0] w;

    tbl  = '{'{10'h2AA, 1'b0}, '{10'h155, 1'b0}, '{10'h0CC, 1'b0}, '{10'h333, 1'b0},
             '{CN, 1'b1}, '{10'h2AA, 1'b0}, '{CP, 1'b1}, '{10'h155, 1'b0}, '{10'h199, 1'b0}};
    pool = '{10'h2AA, 10'h155, 10'h0CC, 10'h333, 10'h199};
    t6 = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
           6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
           6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
           6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    t4 = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
    w  = CN;

    // Reset held with random line activity
    i_rst_n = 1'b0; i_bit_en = 1'b0; i_ser_data = 1'b0;
    repeat (5) begin
      i_bit_en   = 1'($urandom);
      i_ser_data = 1'($urandom);
      @(posedge clk); #1;
    end
    i_bit_en = 1'b0;
    chk("rst_10b", 32'(o_10b), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_comma", 32'(o_is_comma), 32'd0);
    chk("rst_aligned", 32'(o_aligned), 32'd0);
    chk("rst_err", 32'(o_align_err), 32'd0);
    chk("rst_state", 32'(o_state), 32'd0);
    i_rst_n = 1'b1;

    // Lock: junk, three commas; aligned rises on the 30th comma bit
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_word(CN); send_word(CP);
    for (int i = 0; i < 9; i++) send_bit(w[i]);
    chk("lock_pre_aligned", 32'(o_aligned), 32'd0);
    chk("lock_pre_state", 32'(o_state), 32'd1);
    send_bit(w[9]);
    chk("lock_aligned", 32'(o_aligned), 32'd1);
    chk("lock_state", 32'(o_state), 32'd2);
    chk("lock_no_valid", 32'(o_valid), 32'd0);
    track = 1'b1; nb = 0;

    foreach (tbl[i]) begin
      send_word(tbl[i].w);
      chk("tbl_valid", 32'(o_valid), 32'd1);
      chk("tbl_10b", 32'(o_10b), 32'(tbl[i].w));
      chk("tbl_comma", 32'(o_is_comma), 32'(tbl[i].c));
    end

    // Three shifted commas, then an aligned comma clears the error count
    e0 = err_seen;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    repeat (3) send_word(CN);
    for (int i = 0; i < 7; i++) send_bit((i % 2) == 0);
    send_word(CN);
    chk("lossA_errs", 32'(err_seen - e0), 32'd3);
    chk("lossA_aligned", 32'(o_aligned), 32'd1);

    // Four shifted commas drop lock on the fourth
    e0 = err_seen;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    repeat (3) send_word(CN);
    chk("lossB_after3", 32'(o_aligned), 32'd1);
    for (int i = 0; i < 9; i++) send_bit(w[i]);
    chk("lossB_pre", 32'(o_aligned), 32'd1);
    send_bit(w[9]);
    track = 1'b0;
    chk("lossB_aligned", 32'(o_aligned), 32'd0);
    chk("lossB_state", 32'(o_state), 32'd0);
    chk("lossB_hold_10b", 32'(o_10b), 32'(last_push.w));
    settle();
    chk("lossB_errs", 32'(err_seen - e0), 32'd4);

    // Realign in SYNC: 2 commas, 4 junk bits, 3 commas on the new phase
    e0 = err_seen;
    send_word(CN); send_word(CP);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    send_word(CN); send_word(CP);
    for (int i = 0; i < 9; i++) send_bit(w[i]);
    chk("realign_pre", 32'(o_aligned), 32'd0);
    chk("realign_pre_state", 32'(o_state), 32'd1);
    send_bit(w[9]);
    chk("realign_aligned", 32'(o_aligned), 32'd1);
    chk("realign_errs", 32'(err_seen - e0), 32'd1);
    track = 1'b1; nb = 0;

    // Locked stream with random enable gaps
    for (int k = 0; k < 12; k++) begin
      logic [9:0] wv;
      wv = pool[$urandom_range(0, 4)];
      for (int i = 0; i < 10; i++) begin
        send_bit(wv[i]);
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
    end
    settle();
    chk("gap_drain", 32'(sbq.size()), 32'd0);

    // Reset mid-word wins over enable
    track = 1'b0; nb = 0;
    for (int i = 0; i < 4; i++) send_bit(pool[0][i]);
    i_rst_n = 1'b0; i_bit_en = 1'b1; i_ser_data = 1'b1;
    @(posedge clk); #1;
    chk("mrst_state", 32'(o_state), 32'd0);
    chk("mrst_aligned", 32'(o_aligned), 32'd0);
    chk("mrst_valid", 32'(o_valid), 32'd0);
    chk("mrst_10b", 32'(o_10b), 32'd0);
    i_rst_n = 1'b1; i_bit_en = 1'b0;

    // Loopback of an 8b/10b encoded byte ramp after a comma preamble
    e0 = err_seen;
    send_word(CN); send_word(CP); send_word(CN);
    track = 1'b1; nb = 0; rd = 1'b1;
    for (int b = 0; b < 256; b++) begin
      r  = enc(8'(b), rd);
      rd = r[10];
      send_word(r[9:0]);
    end
    settle();
    chk("loop_drain", 32'(sbq.size()), 32'd0);
    chk("loop_errs", 32'(err_seen - e0), 32'd0);
    chk("loop_aligned", 32'(o_aligned), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
